// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: clears a single-port synchronous RAM after reset, then
// shares its port between two requesters with round-robin arbitration.
// Read data returns on a per-requester strobe three cycles after accept.
//
// Handshake: a command transfers in any cycle where reqN_valid && reqN_ready.
// reqN_ready is combinational from the valids and never depends on a
// transfer happening. A requester keeps its command stable while valid is
// high and not yet accepted. Readies stay low during the clear sweep.
module ram_port_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
    logic                init_done_q, init_done_d;
    logic                last_grant_q, last_grant_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    // Read tracking: stage 1 = command registered toward the RAM,
    // stage 2 = RAM has sampled the address, data on ram_dout.
    logic                p1_vld_q, p1_vld_d;
    logic                p1_id_q, p1_id_d;
    logic                p2_vld_q, p2_vld_d;
    logic                p2_id_q, p2_id_d;
    logic                rsp0_q, rsp0_d;
    logic                rsp1_q, rsp1_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                grant0;
    logic                grant1;
    logic                hs;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // State register and all datapath flops, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            init_done_q  <= 1'b0;
            last_grant_q <= 1'b1;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            p1_vld_q     <= 1'b0;
            p1_id_q      <= 1'b0;
            p2_vld_q     <= 1'b0;
            p2_id_q      <= 1'b0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            init_done_q  <= init_done_d;
            last_grant_q <= last_grant_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            p1_vld_q     <= p1_vld_d;
            p1_id_q      <= p1_id_d;
            p2_vld_q     <= p2_vld_d;
            p2_id_q      <= p2_id_d;
            rsp0_q       <= rsp0_d;
            rsp1_q       <= rsp1_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // Next state: sweep every address once, then run forever.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == '1) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end
    end

    // Output decode: round-robin grant; on a tie the requester that did
    // not win last time is served, so continuous contention alternates.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_RUN) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) grant0 = 1'b1;
                else              grant1 = 1'b1;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign hs        = grant0 | grant1;
    assign sel_we    = grant1 ? req1_we    : req0_we;
    assign sel_addr  = grant1 ? req1_addr  : req0_addr;
    assign sel_wdata = grant1 ? req1_wdata : req0_wdata;

    // Datapath: RAM command register, grant history and read pipeline.
    always_comb begin
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        last_grant_d = last_grant_q;
        if (state_q == ST_INIT) begin
            ram_we_d   = 1'b1;
            ram_addr_d = init_cnt_q;
            ram_din_d  = '0;
        end else if (hs) begin
            ram_we_d     = sel_we;
            ram_addr_d   = sel_addr;
            ram_din_d    = sel_wdata;
            last_grant_d = grant1;
        end
        p1_vld_d    = hs & ~sel_we;
        p1_id_d     = grant1;
        p2_vld_d    = p1_vld_q;
        p2_id_d     = p1_id_q;
        rsp0_d      = p2_vld_q & ~p2_id_q;
        rsp1_d      = p2_vld_q & p2_id_q;
        rsp_rdata_d = p2_vld_q ? ram_dout : rsp_rdata_q;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_we;
    logic [2:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       rsp0_valid;
    logic       req1_valid, req1_ready, req1_we;
    logic [2:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       rsp1_valid;
    logic [7:0] rsp_rdata;
    logic       ram_we;
    logic [2:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       init_done;

    int total = 0;
    int bad   = 0;

    // Garbage power-up contents so the clear sweep is observable.
    logic [7:0] mem [8] = '{default: 8'hEE};

    always #5 clk = ~clk;

    // Read-first synchronous RAM: registered read of the sampled address.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    ram_port_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp_rdata  (rsp_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .init_done  (init_done)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " ram_we"},    8'(ram_we),     8'h00);
        chk({tag, " ram_addr"},  8'(ram_addr),   8'h00);
        chk({tag, " ram_din"},   ram_din,        8'h00);
        chk({tag, " init_done"}, 8'(init_done),  8'h00);
        chk({tag, " rdy0"},      8'(req0_ready), 8'h00);
        chk({tag, " rdy1"},      8'(req1_ready), 8'h00);
        chk({tag, " rsp0"},      8'(rsp0_valid), 8'h00);
        chk({tag, " rsp1"},      8'(rsp1_valid), 8'h00);
        chk({tag, " rdata"},     rsp_rdata,      8'h00);
    endtask

    // Entered one time unit after the edge that released reset.
    task automatic check_init(input string tag);
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 3'd4; req0_wdata = 8'h77;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 3'd2; req1_wdata = 8'h00;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("%s rdy0 c%0d", tag, i), 8'(req0_ready), 8'h00);
            chk($sformatf("%s rdy1 c%0d", tag, i), 8'(req1_ready), 8'h00);
            @(posedge clk); #1;
            chk($sformatf("%s ram_we c%0d", tag, i),   8'(ram_we),    8'h01);
            chk($sformatf("%s ram_addr c%0d", tag, i), 8'(ram_addr),  8'(i));
            chk($sformatf("%s ram_din c%0d", tag, i),  ram_din,       8'h00);
            chk($sformatf("%s done c%0d", tag, i),     8'(init_done), 8'(i == 7));
            chk($sformatf("%s rsp0 c%0d", tag, i),     8'(rsp0_valid), 8'h00);
            chk($sformatf("%s rsp1 c%0d", tag, i),     8'(rsp1_valid), 8'h00);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, " ram_we after sweep"}, 8'(ram_we),    8'h00);
        chk({tag, " done held"},          8'(init_done), 8'h01);
    endtask

    // One cycle: drive both requesters, check readies, clock, check responses.
    task automatic step(input string tag,
                        input logic v0, input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                        input logic v1, input logic w1, input logic [2:0] a1, input logic [7:0] d1,
                        input logic e_r0, input logic e_r1,
                        input logic e_p0, input logic e_p1, input logic [7:0] e_data);
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
        #1;
        chk({tag, " rdy0"}, 8'(req0_ready), 8'(e_r0));
        chk({tag, " rdy1"}, 8'(req1_ready), 8'(e_r1));
        @(posedge clk); #1;
        chk({tag, " rsp0"},  8'(rsp0_valid), 8'(e_p0));
        chk({tag, " rsp1"},  8'(rsp1_valid), 8'(e_p1));
        chk({tag, " rdata"}, rsp_rdata,      e_data);
    endtask

    task automatic idle(input string tag, input logic e_p0, input logic e_p1, input logic [7:0] e_data);
        step(tag, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00,
             1'b0, 1'b0, e_p0, e_p1, e_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 3'd0; req0_wdata = 8'h00;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 3'd0; req1_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset1");
        rst = 1'b0;
        check_init("init1");

        // Back-to-back writes then reads from requester 0.
        step("wr_aa", 1'b1, 1'b1, 3'd0, 8'hAA, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("wr_aa ram_we",   8'(ram_we),   8'h01);
        chk("wr_aa ram_addr", 8'(ram_addr), 8'h00);
        chk("wr_aa ram_din",  ram_din,      8'hAA);
        step("wr_bb", 1'b1, 1'b1, 3'd1, 8'hBB, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step("wr_cc", 1'b1, 1'b1, 3'd2, 8'hCC, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step("rd_0",  1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step("rd_1",  1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step("rd_2",  1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA);
        idle("rsp_bb", 1'b1, 1'b0, 8'hBB);
        idle("rsp_cc", 1'b1, 1'b0, 8'hCC);
        idle("hold_cc", 1'b0, 1'b0, 8'hCC);

        // Contention: grants alternate starting with requester 0.
        step("wr_11", 1'b1, 1'b1, 3'd0, 8'h11, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCC);
        step("wr_22", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 8'hCC);
        step("both1", 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCC);
        step("both2", 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hCC);
        step("both3", 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
        step("both4", 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22);
        idle("alt_r0", 1'b1, 1'b0, 8'h11);
        idle("alt_r1", 1'b0, 1'b1, 8'h22);
        idle("alt_end", 1'b0, 1'b0, 8'h22);

        // Unwritten address reads back as cleared.
        step("rd_5", 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
        idle("rd_5_w1", 1'b0, 1'b0, 8'h22);
        idle("rd_5_rsp", 1'b1, 1'b0, 8'h00);
        idle("rd_5_end", 1'b0, 1'b0, 8'h00);

        // Write by requester 1 followed immediately by read by requester 0.
        step("wr_5a", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd3, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step("rd_3",  1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle("raw_w1", 1'b0, 1'b0, 8'h00);
        idle("raw_rsp", 1'b1, 1'b0, 8'h5A);
        idle("raw_end", 1'b0, 1'b0, 8'h5A);

        // Reset one cycle after a read accept drops the read and re-clears.
        step("rd_3b", 1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset("reset2");
        rst = 1'b0;
        check_init("init2");
        step("rd_3c", 1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle("rd_3c_w1", 1'b0, 1'b0, 8'h00);
        idle("rd_3c_rsp", 1'b1, 1'b0, 8'h00);
        idle("rd_3c_end", 1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
